// File: rtl/usb_fifo_sequencer.sv
// usb_fifo_sequencer
// Bridges the SNES B-bus (two registers at $FE/$FF) to an FT245-style USB
// FIFO. SNES strobes and FIFO flags are asynchronous and are synchronized
// before use. A small FSM generates fixed-width FIFO read/write strobes.
// Pending tx bytes take priority over rx prefetch.
//
// Ports
//   clk, rst        : 40 MHz clock, synchronous active-high reset
//   addr, data_in   : raw SNES B-bus address / write data
//   PARD_n, PAWR_n  : raw SNES read / write strobes (active-low)
//   usb_data_in     : byte driven by the FIFO during a read strobe
//   USB_RXFn        : FIFO has rx data (active-low)
//   USB_TXEn        : FIFO can accept tx data (active-low)
//   USB_RDn, USB_WRn, USB_OEn, USB_DIR : registered FIFO/transceiver controls
//   usb_data_out    : tx byte presented to the FIFO
//   data_out, data_oe : byte and drive enable returned to the SNES
//
// Status register at $FE: {4'b0, ovr, unr, ~rx_valid, ~tx_ready}.
module usb_fifo_sequencer #(
    parameter int RD_PULSE = 4,
    parameter int WR_PULSE = 4,
    parameter int RECOVER  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] addr,
    input  logic [7:0] data_in,
    input  logic       PARD_n,
    input  logic       PAWR_n,
    input  logic [7:0] usb_data_in,
    input  logic       USB_RXFn,
    input  logic       USB_TXEn,
    output logic       USB_RDn,
    output logic       USB_WRn,
    output logic       USB_OEn,
    output logic       USB_DIR,
    output logic [7:0] usb_data_out,
    output logic [7:0] data_out,
    output logic       data_oe
);

    localparam int MAX_RW  = (RD_PULSE > WR_PULSE) ? RD_PULSE : WR_PULSE;
    localparam int MAX_CNT = (MAX_RW > RECOVER) ? MAX_RW : RECOVER;
    localparam int CW      = $clog2(MAX_CNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RD      = 2'b01,
        ST_WR      = 2'b10,
        ST_RECOVER = 2'b11
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;

    logic [1:0] pard_sync_r;
    logic [1:0] pawr_sync_r;
    logic [1:0] rxf_sync_r;
    logic [1:0] txe_sync_r;
    logic       pard_prev_r;
    logic       pawr_prev_r;
    logic [7:0] addr_r;
    logic       rd_hit_ff_r;
    logic       rd_hit_fe_r;
    logic       wr_hit_ff_r;

    logic [7:0] shadow_r;
    logic [7:0] rx_buf_r;
    logic       rx_valid_r;
    logic       tx_pending_r;
    logic       ovr_r;
    logic       unr_r;

    logic       pard_s;
    logic       pawr_s;
    logic       rxf_s;
    logic       txe_s;
    logic       rd_ff_s;
    logic       rd_fe_s;
    logic       wr_ff_s;
    logic       tx_go_s;
    logic       rx_go_s;
    logic       rd_last_s;
    logic       wr_last_s;
    logic       tx_ready_s;
    logic [7:0] status_s;

    assign pard_s = pard_sync_r[1];
    assign pawr_s = pawr_sync_r[1];
    assign rxf_s  = rxf_sync_r[1];
    assign txe_s  = txe_sync_r[1];

    // A strobe's target is whatever addr_r held on its last synchronized-low
    // cycle, so the hit flags only update while the strobe is low.
    assign rd_ff_s = pard_s & ~pard_prev_r & rd_hit_ff_r;
    assign rd_fe_s = pard_s & ~pard_prev_r & rd_hit_fe_r;
    assign wr_ff_s = pawr_s & ~pawr_prev_r & wr_hit_ff_r;

    assign tx_go_s    = tx_pending_r & ~txe_s;
    assign rx_go_s    = ~rx_valid_r & ~rxf_s;
    assign rd_last_s  = (state_r == ST_RD) && (cnt_r == {CW{1'b0}});
    assign wr_last_s  = (state_r == ST_WR) && (cnt_r == {CW{1'b0}});
    assign tx_ready_s = ~tx_pending_r & ~txe_s;
    assign status_s   = {4'b0000, ovr_r, unr_r, ~rx_valid_r, ~tx_ready_s};

    // Input synchronizers, strobe edge history and registered address/targets.
    always_ff @(posedge clk) begin
        if (rst) begin
            pard_sync_r <= 2'b11;
            pawr_sync_r <= 2'b11;
            rxf_sync_r  <= 2'b11;
            txe_sync_r  <= 2'b11;
            pard_prev_r <= 1'b1;
            pawr_prev_r <= 1'b1;
            addr_r      <= 8'h00;
            rd_hit_ff_r <= 1'b0;
            rd_hit_fe_r <= 1'b0;
            wr_hit_ff_r <= 1'b0;
        end else begin
            pard_sync_r <= {pard_sync_r[0], PARD_n};
            pawr_sync_r <= {pawr_sync_r[0], PAWR_n};
            rxf_sync_r  <= {rxf_sync_r[0], USB_RXFn};
            txe_sync_r  <= {txe_sync_r[0], USB_TXEn};
            pard_prev_r <= pard_s;
            pawr_prev_r <= pawr_s;
            addr_r      <= addr;
            if (!pard_s) begin
                rd_hit_ff_r <= (addr_r == 8'hFF);
                rd_hit_fe_r <= (addr_r == 8'hFE);
            end
            if (!pawr_s) begin
                wr_hit_ff_r <= (addr_r == 8'hFF);
            end
        end
    end

    // Next-state and counter logic; tx has priority over rx prefetch.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = (cnt_r == {CW{1'b0}}) ? {CW{1'b0}} : cnt_r - {{(CW-1){1'b0}}, 1'b1};
        case (state_r)
            ST_IDLE: begin
                if (tx_go_s) begin
                    next_state_s = ST_WR;
                    cnt_next_s   = CW'(WR_PULSE - 1);
                end else if (rx_go_s) begin
                    next_state_s = ST_RD;
                    cnt_next_s   = CW'(RD_PULSE - 1);
                end else begin
                    next_state_s = ST_IDLE;
                    cnt_next_s   = {CW{1'b0}};
                end
            end
            ST_RD, ST_WR: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_state_s = ST_RECOVER;
                    cnt_next_s   = CW'(RECOVER - 1);
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RECOVER: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RECOVER;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
                cnt_next_s   = {CW{1'b0}};
            end
        endcase
    end

    // FSM state, counter and glitch-free registered FIFO controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            USB_RDn <= 1'b1;
            USB_WRn <= 1'b1;
            USB_OEn <= 1'b1;
            USB_DIR <= 1'b0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
            USB_RDn <= (next_state_s != ST_RD);
            USB_WRn <= (next_state_s != ST_WR);
            USB_OEn <= (next_state_s != ST_RD);
            USB_DIR <= (next_state_s == ST_RD);
        end
    end

    // Data path: write shadow, rx buffer, tx holding register, sticky errors.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r     <= 8'h00;
            rx_buf_r     <= 8'h00;
            rx_valid_r   <= 1'b0;
            tx_pending_r <= 1'b0;
            usb_data_out <= 8'h00;
            ovr_r        <= 1'b0;
            unr_r        <= 1'b0;
        end else begin
            if (!pawr_s && (addr_r == 8'hFF)) begin
                shadow_r <= data_in;
            end
            if (rd_last_s) begin
                rx_buf_r   <= usb_data_in;
                rx_valid_r <= 1'b1;
            end else if (rd_ff_s && rx_valid_r) begin
                rx_valid_r <= 1'b0;
            end
            // usb_data_out only changes while nothing is pending, so it is
            // stable for the whole write strobe.
            if (wr_ff_s && !tx_pending_r) begin
                usb_data_out <= shadow_r;
                tx_pending_r <= 1'b1;
            end else if (wr_last_s) begin
                tx_pending_r <= 1'b0;
            end
            // A fresh error event wins over a status-read clear.
            ovr_r <= (ovr_r & ~rd_fe_s) | (wr_ff_s & tx_pending_r);
            unr_r <= (unr_r & ~rd_fe_s) | (rd_ff_s & ~rx_valid_r);
        end
    end

    // SNES read mux, combinational from the raw bus.
    always_comb begin
        data_out = 8'h00;
        data_oe  = 1'b0;
        if (!PARD_n && (addr == 8'hFF)) begin
            data_out = rx_valid_r ? rx_buf_r : 8'h00;
            data_oe  = 1'b1;
        end else if (!PARD_n && (addr == 8'hFE)) begin
            data_out = status_s;
            data_oe  = 1'b1;
        end else begin
            data_out = 8'h00;
            data_oe  = 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_fifo_sequencer.sv
// Self-checking bench for usb_fifo_sequencer: a table of SNES read-mux
// vectors plus hand-written multi-cycle sequences for the FIFO strobes.
`timescale 1ns/1ps
module tb_usb_fifo_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic       PARD_n;
    logic       PAWR_n;
    logic [7:0] usb_data_in;
    logic       USB_RXFn;
    logic       USB_TXEn;
    logic       USB_RDn;
    logic       USB_WRn;
    logic       USB_OEn;
    logic       USB_DIR;
    logic [7:0] usb_data_out;
    logic [7:0] data_out;
    logic       data_oe;

    int n_checks = 0;
    int n_fail   = 0;

    int         wr_falls = 0;
    int         rd_falls = 0;
    logic [7:0] last_wr_data = 8'h00;
    logic       wrn_q = 1'b1;
    logic       rdn_q = 1'b1;

    typedef struct {
        logic [7:0] a;
        logic       pard_n;
        logic [7:0] exp_d;
        logic       exp_oe;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    usb_fifo_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .data_in     (data_in),
        .PARD_n      (PARD_n),
        .PAWR_n      (PAWR_n),
        .usb_data_in (usb_data_in),
        .USB_RXFn    (USB_RXFn),
        .USB_TXEn    (USB_TXEn),
        .USB_RDn     (USB_RDn),
        .USB_WRn     (USB_WRn),
        .USB_OEn     (USB_OEn),
        .USB_DIR     (USB_DIR),
        .usb_data_out(usb_data_out),
        .data_out    (data_out),
        .data_oe     (data_oe)
    );

    // Count strobe falling edges and capture the tx byte at each write strobe.
    always @(negedge clk) begin
        if (wrn_q && !USB_WRn) begin
            wr_falls     <= wr_falls + 1;
            last_wr_data <= usb_data_out;
        end
        if (rdn_q && !USB_RDn) begin
            rd_falls <= rd_falls + 1;
        end
        wrn_q <= USB_WRn;
        rdn_q <= USB_RDn;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Brief read-mux probe inside the low clock phase; too short to be seen
    // by the PARD_n synchronizer.
    task automatic peek(input logic [7:0] a, output logic [7:0] d, output logic oe);
        logic [7:0] sa;
        @(negedge clk);
        sa     = addr;
        addr   = a;
        PARD_n = 1'b0;
        #1;
        d      = data_out;
        oe     = data_oe;
        addr   = sa;
        PARD_n = 1'b1;
    endtask

    task automatic snes_read(input logic [7:0] a, output logic [7:0] d);
        addr   = a;
        PARD_n = 1'b0;
        #1;
        d = data_out;
        tick(4);
        PARD_n = 1'b1;
        tick(3);
        addr = 8'h00;
    endtask

    task automatic snes_write(input logic [7:0] a, input logic [7:0] d);
        addr    = a;
        data_in = d;
        PAWR_n  = 1'b0;
        tick(4);
        PAWR_n = 1'b1;
        tick(2);
        addr = 8'h00;
    endtask

    task automatic wait_strobe(input logic is_wr, input int budget, input string name);
        int   k;
        logic s;
        k = 0;
        s = is_wr ? USB_WRn : USB_RDn;
        while (s !== 1'b0 && k < budget) begin
            tick(1);
            k++;
            s = is_wr ? USB_WRn : USB_RDn;
        end
        check(name, {31'b0, s}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       oe;
        int         wb;
        int         rb;

        // Read-mux vectors with rx_buf=0x5A valid, TXEn high, no errors.
        vecs[0] = '{8'hFF, 1'b0, 8'h5A, 1'b1};
        vecs[1] = '{8'hFE, 1'b0, 8'h01, 1'b1};
        vecs[2] = '{8'hFF, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'hFE, 1'b1, 8'h00, 1'b0};
        vecs[4] = '{8'hFD, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h7F, 1'b0, 8'h00, 1'b0};
        vecs[6] = '{8'h00, 1'b0, 8'h00, 1'b0};

        rst = 1'b1; addr = 8'h00; data_in = 8'h00; PARD_n = 1'b1; PAWR_n = 1'b1;
        usb_data_in = 8'h5A; USB_RXFn = 1'b1; USB_TXEn = 1'b1;
        tick(3);

        // Reset state
        check("rst_rdn", USB_RDn, 1);
        check("rst_wrn", USB_WRn, 1);
        check("rst_oen", USB_OEn, 1);
        check("rst_dir", USB_DIR, 0);
        check("rst_usb_data_out", usb_data_out, 8'h00);
        check("rst_data_oe", data_oe, 0);
        peek(8'hFE, d, oe);
        check("rst_status", d, 8'h03);
        check("rst_status_oe", oe, 1);
        peek(8'hFF, d, oe);
        check("rst_rx_empty_read", d, 8'h00);
        tick(1);
        rst = 1'b0;
        tick(3);
        check("idle_rdn", USB_RDn, 1);

        // Prefetch: 2 sync cycles + IDLE decision, then a 4-cycle read strobe
        USB_RXFn = 1'b0;
        tick(1); check("lat_c1_rdn", USB_RDn, 1);
        tick(1); check("lat_c2_rdn", USB_RDn, 1);
        tick(1); check("lat_c3_rdn", USB_RDn, 0);
        check("rd_dir", USB_DIR, 1);
        check("rd_oen", USB_OEn, 0);
        check("rd_wrn", USB_WRn, 1);
        for (int i = 1; i < 4; i++) begin
            tick(1);
            check($sformatf("rd_low_%0d", i), USB_RDn, 0);
        end
        tick(1);
        check("rd_end_rdn", USB_RDn, 1);
        check("rd_end_oen", USB_OEn, 1);
        check("rd_end_dir", USB_DIR, 0);
        peek(8'hFE, d, oe);
        check("status_rx_valid", d, 8'h01);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            addr   = vecs[i].a;
            PARD_n = vecs[i].pard_n;
            #1;
            check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_d);
            check($sformatf("vec%0d_oe", i), data_oe, vecs[i].exp_oe);
            addr   = 8'h00;
            PARD_n = 1'b1;
        end
        tick(1);

        // SNES read of $FF returns the byte and triggers the next prefetch
        usb_data_in = 8'hA7;
        snes_read(8'hFF, d);
        check("read_ff_5a", d, 8'h5A);
        rb = rd_falls;
        wait_strobe(1'b0, 10, "prefetch2_rd");
        tick(6);
        check("prefetch2_count", rd_falls, rb + 1);
        peek(8'hFE, d, oe);
        check("status_after_prefetch2", d, 8'h01);

        // SNES write 0xC3 with FIFO ready
        USB_TXEn = 1'b0;
        tick(3);
        wb = wr_falls;
        snes_write(8'hFF, 8'hC3);
        wait_strobe(1'b1, 10, "wr_c3_start");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr_c3_low_%0d", i), USB_WRn, 0);
            check($sformatf("wr_c3_data_%0d", i), usb_data_out, 8'hC3);
            check($sformatf("wr_c3_dir_%0d", i), USB_DIR, 0);
            tick(1);
        end
        check("wr_c3_end", USB_WRn, 1);
        check("wr_c3_count", wr_falls, wb + 1);
        peek(8'hFE, d, oe);
        check("status_after_wr", d, 8'h00);

        // FIFO full: first byte held, second dropped with ovr
        USB_TXEn = 1'b1;
        tick(3);
        wb = wr_falls;
        snes_write(8'hFF, 8'h11);
        tick(3);
        snes_write(8'hFF, 8'h22);
        tick(4);
        check("full_no_wr", wr_falls, wb);
        check("full_held", usb_data_out, 8'h11);
        peek(8'hFE, d, oe);
        check("status_ovr", d, 8'h09);
        USB_TXEn = 1'b0;
        tick(15);
        check("full_one_wr", wr_falls, wb + 1);
        check("full_wr_data", last_wr_data, 8'h11);
        peek(8'hFE, d, oe);
        check("status_ovr_sticky", d, 8'h08);
        tick(1);
        snes_read(8'hFE, d);
        check("status_read_ovr", d, 8'h08);
        peek(8'hFE, d, oe);
        check("status_ovr_cleared", d, 8'h00);
        tick(1);

        // Underrun: drain buffer, then read $FF while empty
        USB_RXFn = 1'b1;
        tick(3);
        snes_read(8'hFF, d);
        check("read_ff_a7", d, 8'hA7);
        peek(8'hFE, d, oe);
        check("status_empty", d, 8'h02);
        tick(1);
        snes_read(8'hFF, d);
        check("read_ff_empty", d, 8'h00);
        peek(8'hFE, d, oe);
        check("status_unr", d, 8'h06);
        tick(1);
        snes_read(8'hFE, d);
        check("status_read_unr", d, 8'h06);
        peek(8'hFE, d, oe);
        check("status_unr_cleared", d, 8'h02);
        tick(1);

        // tx and rx eligible together: write first, RECOVER, IDLE decision, read
        USB_TXEn = 1'b1;
        tick(3);
        snes_write(8'hFF, 8'h3C);
        tick(4);
        usb_data_in = 8'h96;
        USB_RXFn = 1'b0;
        USB_TXEn = 1'b0;
        wait_strobe(1'b1, 10, "both_wr_first");
        check("both_rd_idle", USB_RDn, 1);
        check("both_wr_data", usb_data_out, 8'h3C);
        for (int i = 1; i < 4; i++) begin
            tick(1);
            check($sformatf("both_wr_low_%0d", i), USB_WRn, 0);
        end
        // two RECOVER cycles plus the IDLE decision cycle
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("both_gap_wrn_%0d", i), USB_WRn, 1);
            check($sformatf("both_gap_rdn_%0d", i), USB_RDn, 1);
        end
        tick(1);
        check("both_rd_after", USB_RDn, 0);
        tick(6);

        // Reset in the 2nd cycle of a read strobe
        snes_read(8'hFF, d);
        check("read_ff_96", d, 8'h96);
        wait_strobe(1'b0, 10, "pre_rst_rd");
        tick(1);
        check("rd_2nd_cycle", USB_RDn, 0);
        rst = 1'b1;
        tick(1);
        check("mid_rst_rdn", USB_RDn, 1);
        check("mid_rst_oen", USB_OEn, 1);
        check("mid_rst_dir", USB_DIR, 0);
        check("mid_rst_wrn", USB_WRn, 1);
        peek(8'hFE, d, oe);
        check("mid_rst_status", d, 8'h03);
        tick(1);
        rst = 1'b0;
        tick(1); check("restart_c1", USB_RDn, 1);
        tick(1); check("restart_c2", USB_RDn, 1);
        tick(1); check("restart_c3", USB_RDn, 0);
        tick(6);
        peek(8'hFE, d, oe);
        check("restart_status", d, 8'h00);
        peek(8'hFF, d, oe);
        check("restart_byte", d, 8'h96);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
